// File: rtl/pc_seq_pkg.sv
// Shared opcode definitions for the program-counter sequencer and its bench.
package pc_seq_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
  localparam logic [OP_W-1:0] OP_INC    = 3'b001;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b010;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'b011;
  localparam logic [OP_W-1:0] OP_CALL   = 3'b100;
  localparam logic [OP_W-1:0] OP_RET    = 3'b101;
endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control-matrix decoder and the PC sequencer.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int BitWidth   = 8,
  parameter int StackDepth = 4,
  parameter int SpWidth    = $clog2(StackDepth + 1)
);
  logic [OP_W-1:0]     Op;
  logic [BitWidth-1:0] D;
  logic                OE;
  logic                ClrErr;
  logic [SpWidth-1:0]  Sp;
  logic                Empty;
  logic                Full;
  logic                Err;

  modport master (output Op, D, OE, ClrErr, input Sp, Empty, Full, Err);
  modport slave  (input Op, D, OE, ClrErr, output Sp, Empty, Full, Err);
endinterface

// File: rtl/pc_return_stack.sv
// Register-array LIFO of return addresses; only the depth pointer is reset.
module pc_return_stack #(
  parameter int BitWidth   = 8,
  parameter int StackDepth = 4,
  parameter int SpWidth    = $clog2(StackDepth + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                push,
  input  logic                pop,
  input  logic [BitWidth-1:0] wdata,
  output logic [BitWidth-1:0] rdata,
  output logic [SpWidth-1:0]  Sp,
  output logic                Empty,
  output logic                Full
);
  logic [BitWidth-1:0] mem [StackDepth];
  logic [SpWidth-1:0]  sp_p0;
  logic [SpWidth-1:0]  top_idx;
  logic                do_push;
  logic                do_pop;

  assign Empty   = (sp_p0 == '0);
  assign Full    = (sp_p0 == SpWidth'(StackDepth));
  assign do_push = push && !Full;
  assign do_pop  = pop && !Empty;
  // Guard the empty case so the read index never leaves the array.
  assign top_idx = Empty ? '0 : sp_p0 - 1'b1;
  assign rdata   = mem[top_idx];
  assign Sp      = sp_p0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sp_p0 <= '0;
    end else if (do_push) begin
      sp_p0 <= sp_p0 + 1'b1;
    end else if (do_pop) begin
      sp_p0 <= sp_p0 - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[sp_p0] <= wdata;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with relative branch, call/return stack and tri-state address drive.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int BitWidth   = 8,
  parameter int StackDepth = 4,
  parameter int SpWidth    = $clog2(StackDepth + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  pc_sequencer_if.slave       bus,
  output wire [BitWidth-1:0]  Q
);
  logic [BitWidth-1:0] pc_p0;
  logic [BitWidth-1:0] pc_nxt;
  logic [BitWidth-1:0] rdata;
  logic                push;
  logic                pop;
  logic                fault;
  logic                err_p0;
  logic                stk_empty;
  logic                stk_full;

  function automatic logic [BitWidth-1:0] wrap_add(
    input logic signed [BitWidth-1:0] a,
    input logic signed [BitWidth-1:0] b
  );
    logic signed [BitWidth-1:0] s;
    s = a + b;
    return s;
  endfunction

  pc_return_stack #(
    .BitWidth  (BitWidth),
    .StackDepth(StackDepth),
    .SpWidth   (SpWidth)
  ) u_stack (
    .Clk  (Clk),
    .Reset(Reset),
    .push (push),
    .pop  (pop),
    .wdata(wrap_add(pc_p0, BitWidth'(1))),
    .rdata(rdata),
    .Sp   (bus.Sp),
    .Empty(stk_empty),
    .Full (stk_full)
  );

  always_comb begin
    pc_nxt = pc_p0;
    push   = 1'b0;
    pop    = 1'b0;
    fault  = 1'b0;
    case (bus.Op)
      OP_INC:    pc_nxt = wrap_add(pc_p0, BitWidth'(1));
      OP_LOAD:   pc_nxt = bus.D;
      OP_BRANCH: pc_nxt = wrap_add(pc_p0, bus.D);
      OP_CALL: begin
        if (stk_full) begin
          fault = 1'b1;
        end else begin
          push   = 1'b1;
          pc_nxt = bus.D;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          fault = 1'b1;
        end else begin
          pop    = 1'b1;
          pc_nxt = rdata;
        end
      end
      default: pc_nxt = pc_p0;
    endcase
  end

  // A new fault outranks a simultaneous clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_p0  <= '0;
      err_p0 <= 1'b0;
    end else begin
      pc_p0 <= pc_nxt;
      if (fault) begin
        err_p0 <= 1'b1;
      end else if (bus.ClrErr) begin
        err_p0 <= 1'b0;
      end
    end
  end

  assign bus.Empty = stk_empty;
  assign bus.Full  = stk_full;
  assign bus.Err   = err_p0;
  assign Q         = bus.OE ? {BitWidth{1'bz}} : pc_p0;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed ops queue expected PC/Sp/Err for a monitor.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       err;
    string      name;
  } exp_t;

  logic       Clk;
  logic       Reset;
  wire  [7:0] Q;
  int         n_tests;
  int         n_fail;
  exp_t       sb[$];

  pc_sequencer_if #(.BitWidth(8), .StackDepth(4)) bus ();

  pc_sequencer #(.BitWidth(8), .StackDepth(4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave),
    .Q    (Q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: the DUT presents a result after every edge that consumed a queued op.
  always @(posedge Clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".sp"}, 8'(bus.Sp), 8'(e.sp));
      chk({e.name, ".err"}, 8'(bus.Err), 8'(e.err));
      chk({e.name, ".empty"}, 8'(bus.Empty), 8'(e.sp == 3'd0));
      chk({e.name, ".full"}, 8'(bus.Full), 8'(e.sp == 3'd4));
      if (bus.OE == 1'b0) chk({e.name, ".q"}, Q, e.pc);
    end
  end

  task automatic op(input string name, input logic [2:0] o, input logic [7:0] d,
                    input logic oe, input logic clr,
                    input logic [7:0] pc, input logic [2:0] sp, input logic err);
    exp_t e;
    @(negedge Clk);
    bus.Op     = o;
    bus.D      = d;
    bus.OE     = oe;
    bus.ClrErr = clr;
    e.pc = pc; e.sp = sp; e.err = err; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".q"}, Q, 8'h00);
    chk({name, ".sp"}, 8'(bus.Sp), 8'h00);
    chk({name, ".empty"}, 8'(bus.Empty), 8'h01);
    chk({name, ".full"}, 8'(bus.Full), 8'h00);
    chk({name, ".err"}, 8'(bus.Err), 8'h00);
  endtask

  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    bus.Op = OP_HOLD; bus.D = 8'h00; bus.OE = 1'b0; bus.ClrErr = 1'b0;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    chk_reset_state("reset");
    @(negedge Clk);
    Reset = 1'b1;

    op("inc1", OP_INC, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);
    op("inc2", OP_INC, 8'h00, 1'b0, 1'b0, 8'h02, 3'd0, 1'b0);
    op("inc3", OP_INC, 8'h00, 1'b0, 1'b0, 8'h03, 3'd0, 1'b0);
    op("inc_oe1", OP_INC, 8'h00, 1'b1, 1'b0, 8'h04, 3'd0, 1'b0);
    op("hold_oe0", OP_HOLD, 8'h00, 1'b0, 1'b0, 8'h04, 3'd0, 1'b0);

    op("load_fe", OP_LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 3'd0, 1'b0);
    op("inc_ff", OP_INC, 8'h00, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0);
    op("inc_wrap", OP_INC, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    op("branch_m3", OP_BRANCH, 8'hFD, 1'b0, 1'b0, 8'hFD, 3'd0, 1'b0);
    op("branch_p5", OP_BRANCH, 8'h05, 1'b0, 1'b0, 8'h02, 3'd0, 1'b0);

    op("load_10", OP_LOAD, 8'h10, 1'b0, 1'b0, 8'h10, 3'd0, 1'b0);
    op("call_40", OP_CALL, 8'h40, 1'b0, 1'b0, 8'h40, 3'd1, 1'b0);
    op("call_80", OP_CALL, 8'h80, 1'b0, 1'b0, 8'h80, 3'd2, 1'b0);
    op("ret_41", OP_RET, 8'h00, 1'b0, 1'b0, 8'h41, 3'd1, 1'b0);
    op("ret_11", OP_RET, 8'h00, 1'b0, 1'b0, 8'h11, 3'd0, 1'b0);

    op("fill1", OP_CALL, 8'h01, 1'b0, 1'b0, 8'h01, 3'd1, 1'b0);
    op("fill2", OP_CALL, 8'h02, 1'b0, 1'b0, 8'h02, 3'd2, 1'b0);
    op("fill3", OP_CALL, 8'h03, 1'b0, 1'b0, 8'h03, 3'd3, 1'b0);
    op("fill4", OP_CALL, 8'h04, 1'b0, 1'b0, 8'h04, 3'd4, 1'b0);
    op("call_full", OP_CALL, 8'h09, 1'b0, 1'b0, 8'h04, 3'd4, 1'b1);
    op("clr_err", OP_HOLD, 8'h00, 1'b0, 1'b1, 8'h04, 3'd4, 1'b0);
    op("pop4", OP_RET, 8'h00, 1'b0, 1'b0, 8'h04, 3'd3, 1'b0);
    op("pop3", OP_RET, 8'h00, 1'b0, 1'b0, 8'h03, 3'd2, 1'b0);
    op("pop2", OP_RET, 8'h00, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0);
    op("pop1", OP_RET, 8'h00, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0);
    op("ret_empty", OP_RET, 8'h00, 1'b0, 1'b0, 8'h12, 3'd0, 1'b1);
    op("ret_empty_clr", OP_RET, 8'h00, 1'b0, 1'b1, 8'h12, 3'd0, 1'b1);
    op("clr_err2", OP_HOLD, 8'h00, 1'b0, 1'b1, 8'h12, 3'd0, 1'b0);
    op("op110", 3'b110, 8'h77, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0);
    op("op111", 3'b111, 8'h77, 1'b0, 1'b0, 8'h12, 3'd0, 1'b0);

    op("load_ff", OP_LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 3'd0, 1'b0);
    op("call_at_ff", OP_CALL, 8'h20, 1'b0, 1'b0, 8'h20, 3'd1, 1'b0);
    op("ret_to_00", OP_RET, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);

    op("set_err", OP_RET, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    op("pre_c1", OP_CALL, 8'h30, 1'b0, 1'b0, 8'h30, 3'd1, 1'b1);
    op("pre_c2", OP_CALL, 8'h31, 1'b0, 1'b0, 8'h31, 3'd2, 1'b1);
    op("pre_c3", OP_CALL, 8'h55, 1'b0, 1'b0, 8'h55, 3'd3, 1'b1);
    @(negedge Clk);
    bus.Op = OP_HOLD;

    // Drop Reset mid-cycle and look before any further edge arrives.
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(negedge Clk);
    Reset = 1'b1;
    op("after_reset", OP_INC, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0);

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge Clk);
      guard++;
    end
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
